// File: rtl/nand_timeout_sched_if.sv
// Requester-side bundle for the shared NAND timeout scheduler.
// Defining NAND_TIMEOUT_AUTORELOAD_EN adds the per-channel ch_periodic request.
interface nand_timeout_sched_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  logic [NUM_CH-1:0]       ch_start;
  logic [NUM_CH-1:0]       ch_stop;
  logic [NUM_CH*CNT_W-1:0] ch_load;
  logic [NUM_CH-1:0]       ch_busy;
  logic [NUM_CH-1:0]       ch_done;
  logic                    tick;
  logic [NUM_CH*CNT_W-1:0] ch_remaining;
`ifdef NAND_TIMEOUT_AUTORELOAD_EN
  logic [NUM_CH-1:0]       ch_periodic;

  modport master (
    output ch_start, ch_stop, ch_load, ch_periodic,
    input  ch_busy, ch_done, tick, ch_remaining
  );
  modport slave (
    input  ch_start, ch_stop, ch_load, ch_periodic,
    output ch_busy, ch_done, tick, ch_remaining
  );
`else
  modport master (
    output ch_start, ch_stop, ch_load,
    input  ch_busy, ch_done, tick, ch_remaining
  );
  modport slave (
    input  ch_start, ch_stop, ch_load,
    output ch_busy, ch_done, tick, ch_remaining
  );
`endif
endinterface

// File: rtl/nand_timeout_sched.sv
// Shared prescaled tick plus NUM_CH countdown timeout channels, all on cpld_50m_clk.
// Optional NAND_TIMEOUT_AUTORELOAD_EN: periodic channels reload on expiry instead of idling.
module nand_timeout_sched #(
  parameter int NUM_CH   = 4,
  parameter int PRESCALE = 50000,
  parameter int CNT_W    = 16
) (
  input  logic                 cpld_50m_clk,
  input  logic                 cpld_rst_50m,
  nand_timeout_sched_if.slave  bus
);

  localparam int PW = $clog2(PRESCALE);

  typedef enum logic {IDLE, RUN} ch_state_e;

  logic [PW-1:0]    presc_q;
  logic             tick_q;
  ch_state_e        state_q [NUM_CH];
  ch_state_e        state_d [NUM_CH];
  logic [CNT_W-1:0] rem_q   [NUM_CH];
  logic [CNT_W-1:0] rem_d   [NUM_CH];
  logic [CNT_W-1:0] load_w  [NUM_CH];
  logic [NUM_CH-1:0] done_q;
  logic [NUM_CH-1:0] done_d;

  // tick is registered one count early so it is high exactly while the count is PRESCALE-1
  always_ff @(posedge cpld_50m_clk or posedge cpld_rst_50m) begin
    if (cpld_rst_50m) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= (presc_q == PW'(PRESCALE - 1)) ? '0 : presc_q + PW'(1);
      tick_q  <= (presc_q == PW'(PRESCALE - 2));
    end
  end

  always_ff @(posedge cpld_50m_clk or posedge cpld_rst_50m) begin
    if (cpld_rst_50m) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= IDLE;
        rem_q[i]   <= '0;
      end
      done_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        rem_q[i]   <= rem_d[i];
      end
      done_q <= done_d;
    end
  end

  // priority: stop, then (re)start, then tick countdown
  always_comb begin
    done_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      rem_d[i]   = rem_q[i];
      if (bus.ch_stop[i]) begin
        state_d[i] = IDLE;
        rem_d[i]   = '0;
      end else if (bus.ch_start[i]) begin
        if (load_w[i] != '0) begin
          state_d[i] = RUN;
          rem_d[i]   = load_w[i];
        end else begin
          state_d[i] = IDLE;
          rem_d[i]   = '0;
          done_d[i]  = 1'b1;
        end
      end else if (state_q[i] == RUN && tick_q) begin
        if (rem_q[i] > CNT_W'(1)) begin
          rem_d[i] = rem_q[i] - CNT_W'(1);
        end else begin
          done_d[i] = 1'b1;
`ifdef NAND_TIMEOUT_AUTORELOAD_EN
          if (bus.ch_periodic[i] && load_w[i] != '0) begin
            rem_d[i] = load_w[i];
          end else begin
            state_d[i] = IDLE;
            rem_d[i]   = '0;
          end
`else
          state_d[i] = IDLE;
          rem_d[i]   = '0;
`endif
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign load_w[g]                          = bus.ch_load[g*CNT_W +: CNT_W];
    assign bus.ch_busy[g]                     = (state_q[g] == RUN);
    assign bus.ch_remaining[g*CNT_W +: CNT_W] = rem_q[g];
  end

  assign bus.ch_done = done_q;
  assign bus.tick    = tick_q;

endmodule

// File: tb/tb_nand_timeout_sched.sv
// Directed bench for nand_timeout_sched with PRESCALE=4; expected done cycles are
// derived from the tick phase and queued, then matched against ch_done each cycle.
module tb_nand_timeout_sched;

  localparam int NCH = 4;
  localparam int P   = 4;
  localparam int CW  = 16;

  typedef struct {
    int ch;
    int cyc;
  } exp_t;

  logic cpld_50m_clk = 1'b0;
  logic cpld_rst_50m;
  int   cyc;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  nand_timeout_sched_if #(.NUM_CH(NCH), .CNT_W(CW)) bus();

  nand_timeout_sched #(.NUM_CH(NCH), .PRESCALE(P), .CNT_W(CW)) dut (
    .cpld_50m_clk(cpld_50m_clk),
    .cpld_rst_50m(cpld_rst_50m),
    .bus         (bus)
  );

  always #5 cpld_50m_clk = ~cpld_50m_clk;

  // cycle index counts rising edges since reset was last released
  always @(posedge cpld_50m_clk or posedge cpld_rst_50m) begin
    if (cpld_rst_50m) cyc <= 0;
    else              cyc <= cyc + 1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // ticks are observed at cycles where cyc % P == P-1 and consumed on the following edge
  function automatic int expDone(input int s, input int len);
    int t;
    if (len == 0) return s;
    t = s;
    while (t % P != P - 1) t++;
    return t + P * (len - 1) + 1;
  endfunction

  function automatic logic [63:0] packLoad(input int l0, input int l1, input int l2, input int l3);
    return {CW'(l3), CW'(l2), CW'(l1), CW'(l0)};
  endfunction

  task automatic expectDone(input int ch, input int len);
    exp_t e;
    e.ch  = ch;
    e.cyc = expDone(cyc + 1, len);
    sb.push_back(e);
  endtask

  task automatic cancel(input int ch);
    for (int k = sb.size() - 1; k >= 0; k--)
      if (sb[k].ch == ch) sb.delete(k);
  endtask

  task automatic applyStimulus(input logic [3:0] start, input logic [3:0] stop, input logic [63:0] load);
    bus.ch_start = start;
    bus.ch_stop  = stop;
    bus.ch_load  = load;
    @(negedge cpld_50m_clk);
    bus.ch_start = '0;
    bus.ch_stop  = '0;
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) @(negedge cpld_50m_clk);
  endtask

  always @(negedge cpld_50m_clk) begin : monitor
    logic [NCH-1:0] matched;
    if (!cpld_rst_50m) begin
      matched = '0;
      for (int k = sb.size() - 1; k >= 0; k--) begin
        if (sb[k].cyc == cyc) begin
          matched[sb[k].ch] = 1'b1;
          checkOutput($sformatf("done_on_time_ch%0d", sb[k].ch), 64'(bus.ch_done[sb[k].ch]), 64'd1);
          sb.delete(k);
        end
      end
      for (int i = 0; i < NCH; i++)
        if (bus.ch_done[i] && !matched[i])
          checkOutput($sformatf("unexpected_done_ch%0d", i), 64'(bus.ch_done[i]), 64'd0);
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    cpld_rst_50m = 1'b1;
    bus.ch_start = '0;
    bus.ch_stop  = '0;
    bus.ch_load  = '0;
`ifdef NAND_TIMEOUT_AUTORELOAD_EN
    bus.ch_periodic = '0;
`endif
    repeat (2) @(negedge cpld_50m_clk);
    checkOutput("reset_tick", 64'(bus.tick), 64'd0);
    checkOutput("reset_busy", 64'(bus.ch_busy), 64'd0);
    checkOutput("reset_done", 64'(bus.ch_done), 64'd0);
    checkOutput("reset_remaining", bus.ch_remaining, 64'd0);
    cpld_rst_50m = 1'b0;

    while (cyc < 12) begin
      @(negedge cpld_50m_clk);
      checkOutput("tick_phase", 64'(bus.tick), 64'(cyc % P == P - 1));
    end

    // one-shot on channel 0, armed the cycle after a tick
    expectDone(0, 3);
    applyStimulus(4'b0001, 4'b0000, packLoad(3, 0, 0, 0));
    checkOutput("oneshot_busy", 64'(bus.ch_busy[0]), 64'd1);
    checkOutput("oneshot_rem3", 64'(bus.ch_remaining[15:0]), 64'd3);
    waitUntil(16);
    checkOutput("oneshot_rem2", 64'(bus.ch_remaining[15:0]), 64'd2);
    waitUntil(20);
    checkOutput("oneshot_rem1", 64'(bus.ch_remaining[15:0]), 64'd1);
    waitUntil(23);
    checkOutput("oneshot_busy_before", 64'(bus.ch_busy[0]), 64'd1);
    waitUntil(24);
    checkOutput("oneshot_busy_after", 64'(bus.ch_busy[0]), 64'd0);
    checkOutput("oneshot_rem0", 64'(bus.ch_remaining[15:0]), 64'd0);

    // zero load expires immediately without ever going busy
    waitUntil(26);
    expectDone(1, 0);
    applyStimulus(4'b0010, 4'b0000, packLoad(0, 0, 0, 0));
    checkOutput("zero_busy", 64'(bus.ch_busy[1]), 64'd0);
    waitUntil(28);
    checkOutput("zero_busy_later", 64'(bus.ch_busy[1]), 64'd0);

    // stop on the terminal tick beats the expiry
    waitUntil(28);
    expectDone(2, 1);
    applyStimulus(4'b0100, 4'b0000, packLoad(0, 0, 1, 0));
    checkOutput("abort_rem1", 64'(bus.ch_remaining[47:32]), 64'd1);
    waitUntil(31);
    checkOutput("abort_tick_aligned", 64'(bus.tick), 64'd1);
    cancel(2);
    applyStimulus(4'b0000, 4'b0100, packLoad(0, 0, 0, 0));
    checkOutput("abort_busy", 64'(bus.ch_busy[2]), 64'd0);
    checkOutput("abort_rem", 64'(bus.ch_remaining[47:32]), 64'd0);

    // simultaneous start and stop while running leaves the channel idle
    waitUntil(35);
    expectDone(2, 3);
    applyStimulus(4'b0100, 4'b0000, packLoad(0, 0, 3, 0));
    checkOutput("startstop_running", 64'(bus.ch_busy[2]), 64'd1);
    cancel(2);
    applyStimulus(4'b0100, 4'b0100, packLoad(0, 0, 7, 0));
    checkOutput("startstop_busy", 64'(bus.ch_busy[2]), 64'd0);
    checkOutput("startstop_rem", 64'(bus.ch_remaining[47:32]), 64'd0);

    // concurrent channels, then restart channel 2 mid-run
    waitUntil(40);
    expectDone(0, 2);
    expectDone(1, 2);
    expectDone(2, 5);
    expectDone(3, 1);
    applyStimulus(4'b1111, 4'b0000, packLoad(2, 2, 5, 1));
    checkOutput("conc_busy_all", 64'(bus.ch_busy), 64'hF);
    waitUntil(44);
    checkOutput("conc_done_ch3", 64'(bus.ch_done), 64'h8);
    checkOutput("conc_busy_after3", 64'(bus.ch_busy), 64'h7);
    waitUntil(48);
    checkOutput("conc_done_ch01", 64'(bus.ch_done), 64'h3);
    checkOutput("conc_busy_after01", 64'(bus.ch_busy), 64'h4);
    waitUntil(52);
    checkOutput("restart_rem2", 64'(bus.ch_remaining[47:32]), 64'd2);
    cancel(2);
    expectDone(2, 4);
    applyStimulus(4'b0100, 4'b0000, packLoad(0, 0, 4, 0));
    checkOutput("restart_rem4", 64'(bus.ch_remaining[47:32]), 64'd4);
    waitUntil(67);
    checkOutput("restart_busy_before", 64'(bus.ch_busy[2]), 64'd1);
    checkOutput("restart_rem_last", 64'(bus.ch_remaining[47:32]), 64'd1);
    waitUntil(68);
    checkOutput("restart_busy_after", 64'(bus.ch_busy[2]), 64'd0);

    // asynchronous reset mid-run aborts everything silently
    waitUntil(70);
    for (int i = 0; i < NCH; i++) expectDone(i, 3);
    applyStimulus(4'b1111, 4'b0000, packLoad(3, 3, 3, 3));
    waitUntil(72);
    checkOutput("areset_busy_before", 64'(bus.ch_busy), 64'hF);
    sb.delete();
    #1 cpld_rst_50m = 1'b1;
    #1;
    checkOutput("areset_tick", 64'(bus.tick), 64'd0);
    checkOutput("areset_busy", 64'(bus.ch_busy), 64'd0);
    checkOutput("areset_done", 64'(bus.ch_done), 64'd0);
    checkOutput("areset_remaining", bus.ch_remaining, 64'd0);
    #1 cpld_rst_50m = 1'b0;
    waitUntil(2);
    checkOutput("areset_tick_c2", 64'(bus.tick), 64'd0);
    waitUntil(3);
    checkOutput("areset_tick_c3", 64'(bus.tick), 64'd1);
    waitUntil(20);
    checkOutput("areset_busy_idle", 64'(bus.ch_busy), 64'd0);
    checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
